// File: rtl/mem_port_arbiter.sv
// Arbiter and response router for the RAM port shared by fetch and memory access.
// Data accesses have priority. A burst limiter makes sure a pending fetch still gets through.
module mem_port_arbiter #(
    parameter int unsigned DM_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        pipe_stall,
    output logic [29:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);

    typedef enum logic [1:0] {PendNone, PendIf, PendDm} pend_e;

    pend_e       pend_q, pend_d;
    logic [3:0]  burst_q, burst_d;
    logic [31:0] if_hold_q, dm_hold_q;
    logic        if_err_q, dm_err_q;

    logic dm_act, fetch_forced, grant_dm, grant_if, dm_bad, if_bad;

    always_comb begin
        dm_act       = dm_rd | dm_wr;
        fetch_forced = if_req && (burst_q == 4'(DM_BURST));
        grant_dm     = dm_act && !fetch_forced;
        grant_if     = if_req && !grant_dm;
        dm_bad       = (dm_addr[1:0] != 2'b00) || (dm_rd && dm_wr);
        if_bad       = (if_addr[1:0] != 2'b00);
    end

    always_comb begin
        if_ack      = grant_if;
        dm_ack      = grant_dm;
        pipe_stall  = if_req && !grant_if;
        ram_address = grant_dm ? dm_addr[31:2] : if_addr[31:2];
        ram_wren    = grant_dm && dm_wr && !dm_bad;
        ram_data    = ram_wren ? dm_wdata : 32'h0;

        // Only aligned, legal reads leave a response outstanding.
        pend_d = PendNone;
        if (grant_if && !if_bad) begin
            pend_d = PendIf;
        end else if (grant_dm && dm_rd && !dm_bad) begin
            pend_d = PendDm;
        end

        burst_d = burst_q;
        if (!if_req || grant_if) begin
            burst_d = 4'd0;
        end else if (grant_dm) begin
            burst_d = burst_q + 4'd1;
        end
    end

    always_comb begin
        if_rvalid = (pend_q == PendIf);
        dm_rvalid = (pend_q == PendDm);
        if_rdata  = if_rvalid ? ram_q : if_hold_q;
        dm_rdata  = dm_rvalid ? ram_q : dm_hold_q;
        if_err    = if_err_q;
        dm_err    = dm_err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= PendNone;
            burst_q   <= 4'd0;
            if_hold_q <= 32'h0;
            dm_hold_q <= 32'h0;
            if_err_q  <= 1'b0;
            dm_err_q  <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            burst_q  <= burst_d;
            if_err_q <= grant_if && if_bad;
            dm_err_q <= grant_dm && dm_bad;
            if (pend_q == PendIf) begin
                if_hold_q <= ram_q;
            end
            if (pend_q == PendDm) begin
                dm_hold_q <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a grant model predicts the acks for each cycle.
// Expected responses and error pulses are queued and then checked one cycle later.
module tb_mem_port_arbiter;

    localparam int unsigned DM_BURST = 4;
    localparam logic [1:0] KIfRd = 2'd0, KDmRd = 2'd1, KIfErr = 2'd2, KDmErr = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_rd, dm_wr, dm_ack, dm_rvalid, dm_err;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        pipe_stall, ram_wren;
    logic [29:0] ram_address;
    logic [31:0] ram_data, ram_q;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          tb_burst = 0;
    logic [31:0] last_if = 0, last_dm = 0;
    logic        tb_gif, tb_gdm;
    logic [9:0]  grants;

    mem_port_arbiter #(.DM_BURST(DM_BURST)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .dm_rd      (dm_rd),
        .dm_wr      (dm_wr),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .dm_err     (dm_err),
        .pipe_stall (pipe_stall),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address[7:0]] <= ram_data;
        ram_q <= mem[ram_address[7:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_resp();
        exp_t e;
        logic have;
        have = 1'b0;
        e.kind = KIfRd;
        e.data = 0;
        e.due = 0;
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            have = 1'b1;
            check_eq("resp_due", 32'(e.due), 32'(cyc));
        end
        check_eq("if_rvalid", 32'(if_rvalid), 32'(have && e.kind == KIfRd));
        check_eq("dm_rvalid", 32'(dm_rvalid), 32'(have && e.kind == KDmRd));
        check_eq("if_err", 32'(if_err), 32'(have && e.kind == KIfErr));
        check_eq("dm_err", 32'(dm_err), 32'(have && e.kind == KDmErr));
        if (have && e.kind == KIfRd) last_if = e.data;
        if (have && e.kind == KDmRd) last_dm = e.data;
        check_eq("if_rdata", if_rdata, last_if);
        check_eq("dm_rdata", dm_rdata, last_dm);
    endtask

    task automatic push(input logic [1:0] kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // One clock: check responses and grant outputs at negedge, then step past posedge.
    task automatic cycle();
        logic dact, fwin, gdm, gif, dbad, ibad, wr_ok;
        logic [29:0] exp_addr;
        @(negedge clk);
        cyc++;
        check_resp();
        dact  = dm_rd | dm_wr;
        fwin  = if_req && (tb_burst == int'(DM_BURST));
        gdm   = dact && !fwin;
        gif   = if_req && !gdm;
        dbad  = (dm_addr[1:0] != 2'b00) || (dm_rd && dm_wr);
        ibad  = (if_addr[1:0] != 2'b00);
        wr_ok = gdm && dm_wr && !dbad;
        check_eq("if_ack", 32'(if_ack), 32'(gif));
        check_eq("dm_ack", 32'(dm_ack), 32'(gdm));
        check_eq("pipe_stall", 32'(pipe_stall), 32'(if_req && !gif));
        check_eq("ram_wren", 32'(ram_wren), 32'(wr_ok));
        exp_addr = gdm ? dm_addr[31:2] : if_addr[31:2];
        check_eq("ram_address", 32'(ram_address), 32'(exp_addr));
        if (wr_ok) begin
            check_eq("ram_data", ram_data, dm_wdata);
            ref_mem[dm_addr[9:2]] = dm_wdata;
        end
        if (gif) begin
            if (ibad) push(KIfErr, 0);
            else push(KIfRd, ref_mem[if_addr[9:2]]);
        end
        if (gdm) begin
            if (dbad) push(KDmErr, 0);
            else if (dm_rd) push(KDmRd, ref_mem[dm_addr[9:2]]);
        end
        grants = {grants[8:0], gdm};
        if (!if_req || gif) tb_burst = 0;
        else if (gdm) tb_burst++;
        tb_gif = gif;
        tb_gdm = gdm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA500_0000 ^ (i * 32'h0101_0107);
            ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0107);
        end
        reset = 1'b1;
        if_req = 0; if_addr = 0; dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
        tb_gif = 0; tb_gdm = 0; grants = 0;

        @(negedge clk);
        check_eq("rst_if_ack", 32'(if_ack), 0);
        check_eq("rst_dm_ack", 32'(dm_ack), 0);
        check_eq("rst_if_rvalid", 32'(if_rvalid), 0);
        check_eq("rst_dm_rvalid", 32'(dm_rvalid), 0);
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_dm_rdata", dm_rdata, 0);
        check_eq("rst_errs", 32'({if_err, dm_err}), 0);
        check_eq("rst_stall", 32'(pipe_stall), 0);
        check_eq("rst_ram_addr", 32'(ram_address), 0);
        check_eq("rst_ram_wr", 32'({ram_wren, ram_data != 0}), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Repeated fetch of 0x10
        if_req = 1; if_addr = 32'h10;
        repeat (3) cycle();
        if_req = 0;
        cycle();

        // Simultaneous fetch and data read: data wins, fetch stalls one cycle
        if_req = 1; if_addr = 32'h10; dm_rd = 1; dm_addr = 32'h20;
        cycle();
        dm_rd = 0;
        cycle();
        if_req = 0;
        cycle();

        // Write then read-back of the same word
        dm_wr = 1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        cycle();
        dm_wr = 0; dm_rd = 1;
        cycle();
        dm_rd = 0;
        cycle();
        check_eq("wr_then_rd", dm_rdata, 32'hDEAD_BEEF);

        // Burst limiter: DDDDFDDDDF
        if_req = 1; if_addr = 32'h20; dm_rd = 1; dm_addr = 32'h44; grants = 0;
        repeat (10) cycle();
        check_eq("burst_pattern", 32'(grants), 32'(10'b1111011110));
        if_req = 0; dm_rd = 0;
        cycle();

        // Misaligned data read, then misaligned fetch
        dm_rd = 1; dm_addr = 32'h22;
        cycle();
        dm_rd = 0; if_req = 1; if_addr = 32'h3;
        cycle();
        if_req = 0;
        repeat (2) cycle();

        // Reset lands between a fetch grant and its response
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        check_eq("pre_rst_if_ack", 32'(if_ack), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; if_req = 0;
        exp_q.delete();
        tb_burst = 0; last_if = 0; last_dm = 0;
        repeat (2) cycle();

        // Random traffic; requests held until acked
        for (int n = 0; n < 300; n++) begin
            if (!if_req || tb_gif) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 9) == 0) if_addr[1:0] = 2'($urandom_range(1, 3));
            end
            if (!(dm_rd || dm_wr) || tb_gdm) begin
                dm_rd    = ($urandom_range(0, 2) == 0);
                dm_wr    = ($urandom_range(0, 2) == 0);
                if (dm_rd && dm_wr && $urandom_range(0, 3) != 0) dm_wr = 0;
                dm_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 9) == 0) dm_addr[1:0] = 2'($urandom_range(1, 3));
                dm_wdata = $urandom;
            end
            cycle();
        end
        if_req = 0; dm_rd = 0; dm_wr = 0;
        repeat (2) cycle();
        check_eq("queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
